// File: rtl/ps2_key_controller_if.sv
// rtl/ps2_key_controller_if.sv - PS/2 pins and key-event handshake bundle
interface ps2_key_controller_if;
  logic       kbdclk;
  logic       dat;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] scancode;
  logic       key_break;
  logic       key_ext;
  logic [1:0] keycode;
  logic       key_hit;
  logic       frame_err;
  logic       overrun;

  modport slave (
    input  kbdclk, dat, key_ready,
    output key_valid, scancode, key_break, key_ext, keycode, key_hit,
           frame_err, overrun
  );

  modport master (
    output kbdclk, dat, key_ready,
    input  key_valid, scancode, key_break, key_ext, keycode, key_hit,
           frame_err, overrun
  );
endinterface

// File: rtl/ps2_key_controller.sv
// rtl/ps2_key_controller.sv - PS/2 frame receiver and scan-code to key-event decoder (optional PS2_PARITY_CHECK_EN)
module ps2_key_controller #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_key_controller_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_fall;
  logic                   w_dat;

  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [TW-1:0] r_timer;
  logic          r_ext;
  logic          r_brk;

  logic          w_start;
  logic          w_shift_en;
  logic          w_par_en;
  logic          w_timeout;
  logic          w_byte_done;
  logic          w_stop_err;
  logic          w_parity_ok;
  logic          w_event;

  logic [1:0]    w_keycode;
  logic          w_key_hit;

  logic          r_valid;
  logic [7:0]    r_scancode;
  logic          r_break;
  logic          r_kext;
  logic [1:0]    r_keycode;
  logic          r_key_hit;
  logic          r_frame_err;
  logic          r_overrun;

  // Synchronise the async pins; idle-high reset value avoids a false fall after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.kbdclk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.dat};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_dat  = r_dat_sync[SYNC_STAGES-1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state: a start bit opens a frame, a stall or the stop fall closes it
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall && !w_dat) w_next = S_DATA;
      S_DATA:   if (w_timeout) w_next = S_IDLE;
                else if (w_fall && r_bit_cnt == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_timeout) w_next = S_IDLE;
                else if (w_fall) w_next = S_PARITY == r_state ? S_STOP : r_state;
      S_STOP:   if (w_timeout || w_fall) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: per-fall strobes and frame verdicts
  always_comb begin
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_timeout   = 1'b0;
    w_byte_done = 1'b0;
    w_stop_err  = 1'b0;
    case (r_state)
      S_IDLE:   w_start    = w_fall && !w_dat;
      S_DATA:   w_shift_en = w_fall;
      S_PARITY: w_par_en   = w_fall;
      S_STOP: begin
        w_byte_done = w_fall && w_dat && w_parity_ok;
        w_stop_err  = w_fall && !(w_dat && w_parity_ok);
      end
      default: ;
    endcase
    if (r_state != S_IDLE && !w_fall && r_timer == TMAX) w_timeout = 1'b1;
  end

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;

  // Capture the parity bit for the odd-parity test at the stop fall
  always_ff @(posedge clk) begin
    if (rst)           r_parity <= 1'b0;
    else if (w_par_en) r_parity <= w_dat;
  end

  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  // Bit counter and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else if (w_start) begin
      r_bit_cnt <= 3'd0;
    end else if (w_shift_en) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= {w_dat, r_shift[7:1]};
    end
  end

  // Stall timer: restarts on every fall, parked at zero while idle
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE || w_fall) r_timer <= '0;
    else if (r_timer != TMAX)               r_timer <= r_timer + 1'b1;
  end

  // Prefix tracking: E0/F0 arm flags, any event or bad frame clears them
  always_ff @(posedge clk) begin
    if (rst || w_timeout || w_stop_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_done) begin
      if (r_shift == 8'hE0)      r_ext <= 1'b1;
      else if (r_shift == 8'hF0) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_event = w_byte_done && r_shift != 8'hE0 && r_shift != 8'hF0;

  // Map the WASD scan codes to game key numbers
  always_comb begin
    w_keycode = 2'd0;
    w_key_hit = 1'b1;
    case (r_shift)
      8'h1D:   w_keycode = 2'd0;
      8'h1B:   w_keycode = 2'd1;
      8'h1C:   w_keycode = 2'd2;
      8'h23:   w_keycode = 2'd3;
      default: w_key_hit = 1'b0;
    endcase
  end

  // Output event register: load when empty or being drained, else drop and flag overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_scancode  <= 8'd0;
      r_break     <= 1'b0;
      r_kext      <= 1'b0;
      r_keycode   <= 2'd0;
      r_key_hit   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_timeout || w_stop_err;
      r_overrun   <= w_event && r_valid && !bus.key_ready;
      if (w_event && (!r_valid || bus.key_ready)) begin
        r_valid    <= 1'b1;
        r_scancode <= r_shift;
        r_break    <= r_brk;
        r_kext     <= r_ext;
        r_keycode  <= w_keycode;
        r_key_hit  <= w_key_hit;
      end else if (r_valid && bus.key_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.key_valid = r_valid;
  assign bus.scancode  = r_scancode;
  assign bus.key_break = r_break;
  assign bus.key_ext   = r_kext;
  assign bus.keycode   = r_keycode;
  assign bus.key_hit   = r_key_hit;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_ps2_key_controller.sv
// tb/tb_ps2_key_controller.sv - directed table-driven bench for ps2_key_controller
module tb_ps2_key_controller;

  logic clk;
  logic rst;

  ps2_key_controller_if bus();

  ps2_key_controller #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         n_ev   = 0;
  int         n_ferr = 0;
  int         n_ovr  = 0;
  logic [7:0] last_sc;
  logic [4:0] last_flags;

  // Observe pulses and accepted events away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) n_ferr = n_ferr + 1;
      if (bus.overrun)   n_ovr  = n_ovr + 1;
      if (bus.key_valid && bus.key_ready) begin
        n_ev       = n_ev + 1;
        last_sc    = bus.scancode;
        last_flags = {bus.key_break, bus.key_ext, bus.keycode, bus.key_hit};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic par;
    par = bad_par ? ^b : ~^b;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.dat = frame[i];
      tick(5);
      bus.kbdclk = 1'b0;
      tick(10);
      bus.kbdclk = 1'b1;
      tick(5);
    end
    bus.dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       stop;
    logic       ev;
    logic [7:0] sc;
    logic       brk;
    logic       ext;
    logic [1:0] kc;
    logic       hit;
    logic       ferr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ev0, ferr0, ovr0;

    vecs[0]  = '{8'h1D, 1'b0, 1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{8'h23, 1'b0, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{8'h1D, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
`ifdef PS2_PARITY_CHECK_EN
    vecs[8]  = '{8'h1D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
`else
    vecs[8]  = '{8'h1D, 1'b1, 1'b1, 1'b1, 8'h1D, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
`endif
    vecs[9]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{8'h1B, 1'b0, 1'b1, 1'b1, 8'h1B, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};

    bus.kbdclk    = 1'b1;
    bus.dat       = 1'b1;
    bus.key_ready = 1'b1;
    rst           = 1'b1;
    tick(5);
    check("reset_valid", {31'd0, bus.key_valid}, 32'd0);
    check("reset_scancode", {24'd0, bus.scancode}, 32'd0);
    check("reset_fields", {25'd0, bus.key_break, bus.key_ext, bus.keycode, bus.key_hit,
                           bus.frame_err, bus.overrun}, 32'd0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 11; i++) begin
      ev0   = n_ev;
      ferr0 = n_ferr;
      send_bits(make_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop), 11);
      tick(30);
      check($sformatf("vec%0d_events", i), n_ev - ev0, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d_frame_err", i), n_ferr - ferr0, {31'd0, vecs[i].ferr});
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_scancode", i), {24'd0, last_sc}, {24'd0, vecs[i].sc});
        check($sformatf("vec%0d_flags", i), {27'd0, last_flags},
              {27'd0, vecs[i].brk, vecs[i].ext, vecs[i].kc, vecs[i].hit});
      end
    end

    // Backpressure: first event held, second dropped with overrun
    bus.key_ready = 1'b0;
    ev0  = n_ev;
    ovr0 = n_ovr;
    send_bits(make_frame(8'h1B, 1'b0, 1'b1), 11);
    tick(30);
    check("hold_valid", {31'd0, bus.key_valid}, 32'd1);
    check("hold_scancode", {24'd0, bus.scancode}, 32'h1B);
    send_bits(make_frame(8'h23, 1'b0, 1'b1), 11);
    tick(30);
    check("overrun_pulses", n_ovr - ovr0, 32'd1);
    check("overrun_kept_scancode", {24'd0, bus.scancode}, 32'h1B);
    check("overrun_kept_valid", {31'd0, bus.key_valid}, 32'd1);
    bus.key_ready = 1'b1;
    tick(1);
    check("accept_valid_low", {31'd0, bus.key_valid}, 32'd0);
    check("accept_count", n_ev - ev0, 32'd1);
    check("accept_scancode", {24'd0, last_sc}, 32'h1B);

    // Stall after four data bits: one frame_err from the timeout, then recovery
    ev0   = n_ev;
    ferr0 = n_ferr;
    send_bits(make_frame(8'h1D, 1'b0, 1'b1), 5);
    tick(300);
    check("timeout_frame_err", n_ferr - ferr0, 32'd1);
    check("timeout_no_event", n_ev - ev0, 32'd0);
    send_bits(make_frame(8'h1B, 1'b0, 1'b1), 11);
    tick(30);
    check("after_timeout_event", n_ev - ev0, 32'd1);
    check("after_timeout_scancode", {24'd0, last_sc}, 32'h1B);

    // Reset mid-frame: frame discarded silently
    ev0   = n_ev;
    ferr0 = n_ferr;
    send_bits(make_frame(8'h23, 1'b0, 1'b1), 6);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(300);
    check("rst_mid_no_frame_err", n_ferr - ferr0, 32'd0);
    check("rst_mid_no_event", n_ev - ev0, 32'd0);
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
    tick(30);
    check("after_rst_scancode", {24'd0, last_sc}, 32'h1C);
    check("after_rst_flags", {27'd0, last_flags}, {27'd0, 1'b0, 1'b0, 2'd2, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
